// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB register: word RAM with fixed access latency,
// upstream stall while an access is in flight.
module mem_wb_stage #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemWb,
  input  logic [1:0]  MemMem,
  input  logic [31:0] MemAluRes,
  input  logic [31:0] MemWriteD,
  input  logic [4:0]  MemRd,
  output logic        MemStall,
  output logic [1:0]  WbWb,
  output logic [31:0] WbMemData,
  output logic [31:0] WbAluRes,
  output logic [4:0]  WbRd
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] LAT4 = 4'(LAT);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic acc, done;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] ram [2**DEPTH_LOG2];
  logic unused_bits;

  assign acc = MemMem[1] | MemMem[0];
  assign idx = MemAluRes[DEPTH_LOG2+1:2];
  assign unused_bits = ^{MemAluRes[31:DEPTH_LOG2+2], MemAluRes[1:0]};

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    MemStall = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (LAT4 == 4'd0) begin
            done = 1'b1;
          end else begin
            MemStall = 1'b1;
            state_n  = WAIT;
            cnt_n    = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt < LAT4) begin
          MemStall = 1'b1;
          cnt_n    = cnt + 4'd1;
        end else begin
          done    = 1'b1;
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Reset wins over completion, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && done && MemMem[0])
      ram[idx] <= MemWriteD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WbWb      <= 2'b00;
      WbMemData <= 32'd0;
      WbAluRes  <= 32'd0;
      WbRd      <= 5'd0;
    end else if (MemStall) begin
      WbWb <= 2'b00;
      WbRd <= 5'd0;
    end else begin
      WbWb     <= MemWb;
      WbAluRes <= MemAluRes;
      WbRd     <= MemRd;
      if (done && MemMem[1])
        WbMemData <= ram[idx];
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: LAT=2 instance plus a LAT=0 instance.
module tb_mem_wb_stage;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mwb, mmem;
  logic [31:0] alu, wd;
  logic [4:0]  rd;
  logic        stall;
  logic [1:0]  wwb;
  logic [31:0] wmem, walu;
  logic [4:0]  wrd;

  logic [1:0]  mwb0, mmem0;
  logic [31:0] alu0, wd0;
  logic [4:0]  rd0;
  logic        stall0;
  logic [1:0]  wwb0;
  logic [31:0] wmem0, walu0;
  logic [4:0]  wrd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH_LOG2(10), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .MemWb(mwb), .MemMem(mmem), .MemAluRes(alu),
    .MemWriteD(wd), .MemRd(rd), .MemStall(stall),
    .WbWb(wwb), .WbMemData(wmem), .WbAluRes(walu), .WbRd(wrd)
  );

  mem_wb_stage #(.DEPTH_LOG2(10), .LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .MemWb(mwb0), .MemMem(mmem0), .MemAluRes(alu0),
    .MemWriteD(wd0), .MemRd(rd0), .MemStall(stall0),
    .WbWb(wwb0), .WbMemData(wmem0), .WbAluRes(walu0), .WbRd(wrd0)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Presents one access to the LAT=2 instance and walks it to completion.
  task automatic access(input string tag, input logic [1:0] w,
                        input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
    mwb = w; mmem = m; alu = a; wd = d; rd = r;
    for (int i = 0; i < LAT; i++) begin
      #1;
      check({tag, "_stall_hi"}, 32'(stall), 32'd1);
      edge1();
      check({tag, "_bubble_wb"}, 32'(wwb), 32'd0);
      check({tag, "_bubble_rd"}, 32'(wrd), 32'd0);
    end
    check({tag, "_stall_lo"}, 32'(stall), 32'd0);
    edge1();
  endtask

  task automatic step0(input string tag, input logic [1:0] w,
                       input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    mwb0 = w; mmem0 = m; alu0 = a; wd0 = d; rd0 = r;
    #1;
    check({tag, "_stall0"}, 32'(stall0), 32'd0);
    edge1();
  endtask

  initial begin
    rst = 1'b1;
    mwb = 2'b11; mmem = 2'b10; alu = 32'h44; wd = 32'h1; rd = 5'd9;
    mwb0 = 2'b00; mmem0 = 2'b00; alu0 = 32'h0; wd0 = 32'h0; rd0 = 5'd0;
    edge1();
    check("rst_wb", 32'(wwb), 32'd0);
    check("rst_mem", wmem, 32'd0);
    check("rst_alu", walu, 32'd0);
    check("rst_rd", 32'(wrd), 32'd0);
    rst = 1'b0;
    mmem = 2'b00; mwb = 2'b00;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    edge1();

    access("st", 2'b00, 2'b01, 32'h10, 32'hDEADBEEF, 5'd0);
    check("st_alu", walu, 32'h10);
    check("st_wb", 32'(wwb), 32'd0);

    access("ld", 2'b11, 2'b10, 32'h10, 32'h0, 5'd3);
    check("ld_data", wmem, 32'hDEADBEEF);
    check("ld_wb", 32'(wwb), 32'd3);
    check("ld_rd", 32'(wrd), 32'd3);

    mwb = 2'b10; mmem = 2'b00; alu = 32'h1234; rd = 5'd7;
    #1;
    check("alu_stall", 32'(stall), 32'd0);
    edge1();
    check("alu_res", walu, 32'h1234);
    check("alu_rd", 32'(wrd), 32'd7);
    check("alu_wb", 32'(wwb), 32'd2);
    check("alu_memhold", wmem, 32'hDEADBEEF);
    check("alu_stall2", 32'(stall), 32'd0);

    access("wst", 2'b00, 2'b01, 32'h1003, 32'hA5A5A5A5, 5'd0);
    access("wld", 2'b11, 2'b10, 32'h0000, 32'h0, 5'd4);
    check("wrap_data", wmem, 32'hA5A5A5A5);

    access("zst", 2'b00, 2'b01, 32'h20, 32'h0, 5'd0);
    mwb = 2'b00; mmem = 2'b01; alu = 32'h20; wd = 32'h55; rd = 5'd0;
    #1;
    check("ab_stall1", 32'(stall), 32'd1);
    edge1();
    check("ab_stall2", 32'(stall), 32'd1);
    rst = 1'b1;
    edge1();
    check("ab_wb", 32'(wwb), 32'd0);
    check("ab_mem", wmem, 32'd0);
    check("ab_alu", walu, 32'd0);
    check("ab_rd", 32'(wrd), 32'd0);
    rst = 1'b0;
    mmem = 2'b00;
    #1;
    check("ab_idle", 32'(stall), 32'd0);
    edge1();
    access("abld", 2'b11, 2'b10, 32'h20, 32'h0, 5'd5);
    check("ab_ram", wmem, 32'h0);
    mmem = 2'b00; mwb = 2'b00;

    step0("z_st1", 2'b00, 2'b01, 32'h4, 32'h11111111, 5'd0);
    check("z_st1_alu", walu0, 32'h4);
    step0("z_ld1", 2'b11, 2'b10, 32'h4, 32'h0, 5'd6);
    check("z_ld1_data", wmem0, 32'h11111111);
    check("z_ld1_rd", 32'(wrd0), 32'd6);
    step0("z_alu", 2'b10, 2'b00, 32'h99, 32'h0, 5'd8);
    check("z_alu_res", walu0, 32'h99);
    check("z_alu_hold", wmem0, 32'h11111111);
    step0("z_rw", 2'b11, 2'b11, 32'h4, 32'h22, 5'd9);
    check("z_rw_old", wmem0, 32'h11111111);
    step0("z_ld2", 2'b11, 2'b10, 32'h4, 32'h0, 5'd10);
    check("z_ld2_data", wmem0, 32'h22);
    check("z_ld2_wb", 32'(wwb0), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the MIPS pipeline, placed directly downstream of the EX/MEM pipeline register. It performs loads and stores against an internal word-addressed data RAM with a fixed, parameterised access latency. It asserts a stall to the upstream stages while an access is in flight, and registers the results into the MEM/WB pipeline outputs consumed by write-back.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of data RAM depth in 32-bit words.
- LAT, 2: wait cycles per memory access (0 = single-cycle, no stall). Legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- MemWb  input  2  WB control from EX/MEM: [1]=RegWrite, [0]=MemToReg.
- MemMem  input  2  MEM control from EX/MEM: [1]=MemRead, [0]=MemWrite.
- MemAluRes  input  32  ALU result; byte address for loads/stores.
- MemWriteD  input  32  store data.
- MemRd  input  5  destination register.
- MemStall  output  1  combinational; 1 = upstream (PC, IF/ID, ID/EX, EX/MEM) must hold.
- WbWb  output  2  registered WB control.
- WbMemData  output  32  registered load data.
- WbAluRes  output  32  registered ALU result.
- WbRd  output  5  registered destination register.

## Operation
- Access = MemMem[1] | MemMem[0]. RAM word index = MemAluRes[DEPTH_LOG2+1:2]. Bits [1:0] ignored. Higher bits ignored, so out-of-range addresses wrap.
- FSM states:
  - IDLE: no access in flight.
  - WAIT: access in flight; 4-bit counter cnt counts elapsed wait cycles.
- IDLE with Access and LAT>0: MemStall=1, go to WAIT with cnt=1.
- IDLE with Access and LAT=0: no stall; complete the access this cycle.
- WAIT with cnt<LAT: MemStall=1, cnt increments.
- WAIT with cnt==LAT: MemStall=0, access completes, go to IDLE.
- Completion edge:
  - If MemWrite, RAM[index] <= MemWriteD.
  - If MemRead, WbMemData <= RAM[index] (value before any same-edge write).
  - WbWb/WbAluRes/WbRd load from the inputs.
- Each stall cycle loads a bubble into MEM/WB: WbWb=0, WbRd=0. WbAluRes and WbMemData hold their values. No RAM write occurs.
- Non-access instruction in IDLE: MEM/WB loads the inputs every cycle. WbMemData holds its value.
- Both MemRead and MemWrite set: the store is performed and WbMemData returns the old word (read-before-write).
- Inputs are held stable by upstream while MemStall=1. The block does not re-latch them.

## Timing
- Reset (rst=1 at an edge): state=IDLE, cnt=0, WbWb=0, WbMemData=0, WbAluRes=0, WbRd=0.
  - MemStall=0 in the cycle after reset; it then follows the combinational rules above.
  - RAM contents are not reset.
- Reset during WAIT aborts the access. A pending store is discarded (RAM unchanged) and no load result is produced.
- Access latency: an access presented at cycle t completes at the edge ending cycle t+LAT. MemStall is high for exactly LAT cycles (t..t+LAT-1).
- Back-to-back accesses: the next access starts in IDLE on the cycle after completion. Each access incurs the full LAT.
- Non-access instructions pass through with 1-cycle latency and no stall.
- Synthesis: the RAM is a synchronous-write array with combinational read (index is stable during the access).

## Test plan
- Reset: drive inputs nonzero, assert rst for 1 edge -> all Wb* outputs 0, MemStall 0, FSM IDLE.
- Store then load (LAT=2):
  - Store: MemMem=01, MemAluRes=0x10, MemWriteD=0xDEADBEEF. MemStall high 2 cycles; RAM[4]=0xDEADBEEF after the 3rd edge; WbWb=0 during the stall.
  - Load: MemMem=10, MemWb=11, MemAluRes=0x10 -> WbMemData=0xDEADBEEF, WbWb=11 after 3 edges.
- ALU pass-through: MemMem=00, MemWb=10, MemAluRes=0x1234, MemRd=7 -> next edge WbAluRes=0x1234, WbRd=7, WbWb=10, MemStall 0 throughout.
- Wrap and alignment (DEPTH_LOG2=10): store 0xA5A5A5A5 to 0x1003 -> load from 0x0000 returns 0xA5A5A5A5.
- Abort: store 0x55 to 0x20 (prior content 0x0); rst=1 on the 2nd stall cycle -> RAM[8] stays 0x0, outputs reset, a later load of 0x20 returns 0x0.
- LAT=0 build: alternating load/store/ALU stream -> MemStall never 1, one result per cycle, RAM updated at each store edge.
